// File: rtl/result_monitor.sv
// Receiving-side checker for the dice/traffic-light multiplexer: validates the result stream
// per mode, freezes thrown dice, counts violations. Optional 7-segment output: MONITOR_SEG_EN.
module result_monitor #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic             sel,
    input  logic [2:0]       result,
    output logic [2:0]       shown,
    output logic             held,
    output logic             err,
    output logic [ERR_W-1:0] err_count
`ifdef MONITOR_SEG_EN
    ,
    output logic [6:0]       seg
`endif
);

    typedef enum logic [1:0] {RESYNC, TRAFFIC, ROLL, HELD} state_t;

    state_t     state, state_nxt;
    logic [2:0] r_result, last, last_nxt, shown_nxt;
    logic       b_q, b_q_d, s_q, s_q_d, err_nxt;

    function automatic logic is_light(input logic [2:0] c);
        return (c == 3'b100) || (c == 3'b110) || (c == 3'b001) || (c == 3'b010);
    endfunction

    function automatic logic [2:0] succ(input logic [2:0] c);
        case (c)
            3'b100:  return 3'b110;
            3'b110:  return 3'b001;
            3'b001:  return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        shown_nxt = shown;
        err_nxt   = 1'b0;
        if (s_q != s_q_d) begin
            state_nxt = RESYNC;
        end else begin
            case (state)
                RESYNC: begin
                    if (!s_q) begin
                        state_nxt = TRAFFIC;
                        last_nxt  = r_result;
                    end else if (b_q) begin
                        state_nxt = ROLL;
                    end else begin
                        state_nxt = HELD;
                        shown_nxt = r_result;
                    end
                end
                TRAFFIC: begin
                    shown_nxt = r_result;
                    if (is_light(r_result)) begin
                        last_nxt = r_result;
                        // An illegal code loaded at resync means the next legal code starts a fresh sequence.
                        if (is_light(last) && r_result != last && r_result != succ(last))
                            err_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                ROLL: begin
                    shown_nxt = r_result;
                    err_nxt   = (r_result == 3'd0) || (r_result == 3'd7);
                    if (b_q_d && !b_q)
                        state_nxt = HELD;
                end
                HELD: begin
                    if (!b_q_d && b_q)
                        state_nxt = ROLL;
                end
                default: state_nxt = RESYNC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Red on reset so the first resync leaves last at red.
            r_result  <= 3'b100;
            b_q       <= 1'b0;
            b_q_d     <= 1'b0;
            s_q       <= 1'b0;
            s_q_d     <= 1'b0;
            state     <= RESYNC;
            last      <= 3'b100;
            shown     <= 3'b000;
            held      <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            r_result <= result;
            b_q      <= button;
            b_q_d    <= b_q;
            s_q      <= sel;
            s_q_d    <= s_q;
            state    <= state_nxt;
            last     <= last_nxt;
            shown    <= shown_nxt;
            held     <= (state_nxt == HELD);
            err      <= err_nxt;
            if (err_nxt && err_count != '1)
                err_count <= err_count + 1'b1;
        end
    end

`ifdef MONITOR_SEG_EN
    always_comb begin
        case (shown)
            3'd0:    seg = 7'b0111111;
            3'd1:    seg = 7'b0000110;
            3'd2:    seg = 7'b1011011;
            3'd3:    seg = 7'b1001111;
            3'd4:    seg = 7'b1100110;
            3'd5:    seg = 7'b1101101;
            3'd6:    seg = 7'b1111101;
            default: seg = 7'b0000111;
        endcase
    end
`endif

endmodule

// File: tb/tb_result_monitor.sv
module tb_result_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       button, sel;
    logic [2:0] result;
    logic [2:0] shown;
    logic       held, err;
    logic [7:0] err_count;
`ifdef MONITOR_SEG_EN
    logic [6:0] seg;
`endif

    result_monitor #(.ERR_W(8)) dut (
        .clk(clk), .rst(rst), .button(button), .sel(sel), .result(result),
        .shown(shown), .held(held), .err(err), .err_count(err_count)
`ifdef MONITOR_SEG_EN
        , .seg(seg)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] shown;
        logic       held;
        logic       err;
        int         cnt;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   edge_n  = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam int D_RES [12] = '{1, 2, 3, 4, 5, 6, 1, 2, 3, 4, 5, 6};
    localparam int D_BTN [12] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    localparam int D_SH  [12] = '{4, 4, 4, 3, 4, 4, 4, 4, 4, 4, 4, 5};
    localparam int D_HD  [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    localparam int M_RES [7]  = '{5, 5, 4, 4, 1, 1, 1};
    localparam int M_SH  [7]  = '{3, 3, 3, 4, 4, 1, 1};
    localparam int M_ERR [7]  = '{0, 0, 0, 0, 0, 1, 0};
    localparam int A_SEQ [5]  = '{4, 6, 1, 2, 4};

`ifdef MONITOR_SEG_EN
    function automatic logic [6:0] glyph(input logic [2:0] v);
        case (v)
            3'd0: return 7'b0111111;  3'd1: return 7'b0000110;
            3'd2: return 7'b1011011;  3'd3: return 7'b1001111;
            3'd4: return 7'b1100110;  3'd5: return 7'b1101101;
            3'd6: return 7'b1111101;  default: return 7'b0000111;
        endcase
    endfunction
`endif

    task automatic drv(input logic [2:0] r, input logic b, input logic s);
        result = r;
        button = b;
        sel    = s;
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic chk(input int dc, input logic [2:0] sh, input logic hd, input logic er,
                       input int c, input string nm);
        exp_t x;
        x.cyc = edge_n + dc; x.shown = sh; x.held = hd; x.err = er; x.cnt = c; x.name = nm;
        q.push_back(x);
    endtask

    task automatic chk_rst(input string nm);
        logic bad;
        #1;
        n_tests++;
        bad = shown !== 3'd0 || held !== 1'b0 || err !== 1'b0 || err_count !== 8'd0;
`ifdef MONITOR_SEG_EN
        bad = bad || (seg !== 7'b0111111);
`endif
        if (bad) begin
            n_fail++;
            $display("FAIL %s: in reset shown=%0d held=%0b err=%0b cnt=%0d",
                     nm, shown, held, err, err_count);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= edge_n) begin
            logic bad;
            e = q.pop_front();
            n_tests++;
            bad = (e.cyc != edge_n) || shown !== e.shown || held !== e.held || err !== e.err ||
                  int'(err_count) != e.cnt;
`ifdef MONITOR_SEG_EN
            bad = bad || (seg !== glyph(e.shown));
`endif
            if (bad) begin
                n_fail++;
                $display("FAIL %s @edge %0d (due %0d): shown=%0d want %0d held=%0b want %0b err=%0b want %0b cnt=%0d want %0d",
                         e.name, edge_n, e.cyc, shown, e.shown, held, e.held, err, e.err,
                         err_count, e.cnt);
            end
        end
    end

    initial begin
        rst = 1'b1; result = 3'b100; button = 1'b0; sel = 1'b0;
        chk_rst("reset_state_init");
        chk(0, 3'd0, 1'b0, 1'b0, 0, "reset_init");
        @(negedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 3; j++) begin
                drv(3'(A_SEQ[i]), 1'b0, 1'b0);
                chk(1, 3'(A_SEQ[i]), 1'b0, 1'b0, 0, "traffic_legal");
            end

        drv(3'b001, 1'b0, 1'b0); chk(1, 3'b001, 1'b0, 1'b1, 1, "traffic_skip");
        drv(3'b111, 1'b0, 1'b0); chk(1, 3'b111, 1'b0, 1'b1, 2, "traffic_badcode");
        drv(3'b010, 1'b0, 1'b0); chk(1, 3'b010, 1'b0, 1'b0, 2, "traffic_last_kept");

        for (int i = 0; i < 3; i++) begin
            drv(3'b111, 1'b0, 1'b0);
            chk(1, 3'b111, 1'b0, 1'b1, 3 + i, "count_up");
        end
        drv(3'b010, 1'b0, 1'b0); chk(1, 3'b010, 1'b0, 1'b0, 5, "count_at5");
        drv(3'b010, 1'b0, 1'b0);
        drv(3'b100, 1'b0, 1'b0);
        rst = 1'b1;
        chk_rst("reset_state_mid");
        chk(0, 3'd0, 1'b0, 1'b0, 0, "reset_mid");
        @(negedge clk); #1 rst = 1'b0;
        drv(3'b100, 1'b0, 1'b0); chk(0, 3'd0, 1'b0, 1'b0, 0, "resync_quiet");
        drv(3'b100, 1'b0, 1'b0); chk(0, 3'b100, 1'b0, 1'b0, 0, "traffic_resumed");

        for (int i = 0; i < 12; i++) begin
            drv(3'(D_RES[i]), D_BTN[i] != 0, 1'b1);
            chk(0, 3'(D_SH[i]), D_HD[i] != 0, 1'b0, 0, "dice_capture");
        end

        drv(3'd0, 1'b1, 1'b1); chk(1, 3'd0, 1'b0, 1'b1, 1, "dice_zero");
        for (int i = 0; i < 300; i++) begin
            drv(3'd7, 1'b1, 1'b1);
            if (i == 0)   chk(1, 3'd7, 1'b0, 1'b1, 2, "dice_seven");
            if (i == 299) chk(1, 3'd7, 1'b0, 1'b1, 255, "count_saturated");
        end
        drv(3'd3, 1'b1, 1'b1); chk(1, 3'd3, 1'b0, 1'b0, 255, "dice_valid_after");

        for (int i = 0; i < 7; i++) begin
            drv(3'(M_RES[i]), 1'b1, 1'b0);
            chk(0, 3'(M_SH[i]), 1'b0, M_ERR[i] != 0, 255, "mode_switch");
        end

        repeat (3) drv(3'b001, 1'b1, 1'b0);
        while (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: expectation due at edge %0d never checked (now %0d)",
                     x.name, x.cyc, edge_n);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
